// File: rtl/fetch_pkg.sv
// Shared fetch/branch decode constants used by the fetch stage and the later resolvers.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;

    // SPECIAL funct codes
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    // REGIMM rt codes that are branches
    localparam logic [4:0] RT_BLTZ    = 5'b00000;
    localparam logic [4:0] RT_BGEZ    = 5'b00001;
    localparam logic [4:0] RT_BLTZAL  = 5'b10000;
    localparam logic [4:0] RT_BGEZAL  = 5'b10001;

    // Word offset of a PC-relative branch, sign-extended to 32 bits.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_bht.sv
// Branch history table: 2-bit saturating counters, combinational read, one sync update.
module fetch_bht #(
    parameter int unsigned BHT_BITS = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BHT_BITS-1:0] rd_idx,
    output logic [1:0]          rd_ctr,
    input  logic                upd_en,
    input  logic [BHT_BITS-1:0] upd_idx,
    input  logic                upd_taken
);

    localparam int unsigned Entries = 1 << BHT_BITS;

    logic [1:0] ctr_q [Entries];
    logic [1:0] ctr_d [Entries];

    // Read returns the pre-update value; a same-cycle update shows up next cycle.
    assign rd_ctr = ctr_q[rd_idx];

    // Saturating increment/decrement of the addressed counter.
    always_comb begin
        ctr_d = ctr_q;
        if (upd_en) begin
            if (upd_taken) begin
                if (ctr_q[upd_idx] != 2'b11) ctr_d[upd_idx] = ctr_q[upd_idx] + 2'd1;
            end else begin
                if (ctr_q[upd_idx] != 2'b00) ctr_d[upd_idx] = ctr_q[upd_idx] - 2'd1;
            end
        end
    end

    // Counter array, reset to weakly not-taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < Entries; i++) ctr_q[i] <= 2'b01;
        end else begin
            ctr_q <= ctr_d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, predecode, BHT prediction and delay-slot sequencing.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned BHT_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_F,
    input  logic        redirect_E,
    input  logic [31:0] redirect_pc_E,
    input  logic        bht_update_E,
    input  logic [31:0] bht_pc_E,
    input  logic        bht_taken_E,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst_rdata,
    output logic [31:0] pc_F,
    output logic [31:0] pc_plus_F,
    output logic [31:0] pc_jump_F,
    output logic [31:0] instr_F,
    output logic        jump_F,
    output logic        branch_F,
    output logic        is_jr_F,
    output logic        pred_take_F,
    output logic        F_change
);

    logic [31:0] pc_q, pc_d;
    logic        pend_v_q, pend_v_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic        slot_q, slot_d;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rt;
    logic [1:0]  bht_ctr;
    logic        unused_bht_pc;

    assign opcode = inst_rdata[31:26];
    assign funct  = inst_rdata[5:0];
    assign rt     = inst_rdata[20:16];

    assign pc_F      = pc_q;
    assign inst_addr = pc_q;
    assign pc_plus_F = pc_q + 32'd4;
    assign instr_F   = inst_rdata;
    assign F_change  = slot_q;

    assign unused_bht_pc = ^{bht_pc_E[31:BHT_BITS+2], bht_pc_E[1:0]};

    fetch_bht #(
        .BHT_BITS (BHT_BITS)
    ) u_bht (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (pc_q[BHT_BITS+1:2]),
        .rd_ctr    (bht_ctr),
        .upd_en    (bht_update_E),
        .upd_idx   (bht_pc_E[BHT_BITS+1:2]),
        .upd_taken (bht_taken_E)
    );

    // Predecode of the fetched word and its static target.
    always_comb begin
        jump_F   = 1'b0;
        branch_F = 1'b0;
        is_jr_F  = 1'b0;
        case (opcode)
            OP_J, OP_JAL:                    jump_F   = 1'b1;
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: branch_F = 1'b1;
            OP_REGIMM: begin
                branch_F = (rt == RT_BLTZ) || (rt == RT_BGEZ) ||
                           (rt == RT_BLTZAL) || (rt == RT_BGEZAL);
            end
            OP_SPECIAL: is_jr_F = (funct == FN_JR) || (funct == FN_JALR);
            default: ;
        endcase

        if (jump_F) begin
            pc_jump_F = {pc_plus_F[31:28], inst_rdata[25:0], 2'b00};
        end else if (branch_F) begin
            pc_jump_F = pc_plus_F + branch_offset(inst_rdata[15:0]);
        end else begin
            pc_jump_F = 32'd0;
        end

        pred_take_F = branch_F & bht_ctr[1];
    end

    // Next PC: redirect beats stall; a pending target is taken after its delay slot.
    always_comb begin
        pc_d       = pc_q;
        pend_v_d   = pend_v_q;
        pend_tgt_d = pend_tgt_q;
        slot_d     = slot_q;
        if (redirect_E) begin
            pc_d     = redirect_pc_E;
            pend_v_d = 1'b0;
            slot_d   = 1'b0;
        end else if (!stall_F) begin
            if (pend_v_q) begin
                // Current instruction is the delay slot; its own flags are ignored.
                pc_d     = pend_tgt_q;
                pend_v_d = 1'b0;
                slot_d   = 1'b0;
            end else begin
                pc_d = pc_plus_F;
                if (jump_F || pred_take_F) begin
                    pend_v_d   = 1'b1;
                    pend_tgt_d = pc_jump_F;
                end
                slot_d = jump_F | branch_F | is_jr_F;
            end
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            pend_v_q   <= 1'b0;
            pend_tgt_q <= 32'd0;
            slot_q     <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pend_v_q   <= pend_v_d;
            pend_tgt_q <= pend_tgt_d;
            slot_q     <= slot_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small combinational instruction ROM.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_F = 1'b0;
    logic        redirect_E = 1'b0;
    logic [31:0] redirect_pc_E = 32'd0;
    logic        bht_update_E = 1'b0;
    logic [31:0] bht_pc_E = 32'd0;
    logic        bht_taken_E = 1'b0;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic [31:0] pc_F, pc_plus_F, pc_jump_F, instr_F;
    logic        jump_F, branch_F, is_jr_F, pred_take_F, F_change;

    int n_checks = 0;
    int n_errors = 0;

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall_F       (stall_F),
        .redirect_E    (redirect_E),
        .redirect_pc_E (redirect_pc_E),
        .bht_update_E  (bht_update_E),
        .bht_pc_E      (bht_pc_E),
        .bht_taken_E   (bht_taken_E),
        .inst_addr     (inst_addr),
        .inst_rdata    (inst_rdata),
        .pc_F          (pc_F),
        .pc_plus_F     (pc_plus_F),
        .pc_jump_F     (pc_jump_F),
        .instr_F       (instr_F),
        .jump_F        (jump_F),
        .branch_F      (branch_F),
        .is_jr_F       (is_jr_F),
        .pred_take_F   (pred_take_F),
        .F_change      (F_change)
    );

    always #5 clk = ~clk;

    // Instruction ROM; everything else reads as sll $0,$0,0.
    always_comb begin
        case (inst_addr)
            32'hBFC0_0010: inst_rdata = 32'h0BF0_0040; // j   0xBFC00100
            32'hBFC0_0020: inst_rdata = 32'h1000_FFFC; // beq $0,$0,-4
            32'h8000_1004: inst_rdata = 32'h03E0_0008; // jr  $31
            32'h8000_100C: inst_rdata = 32'h0401_0004; // bgez $0,+4
            default:       inst_rdata = 32'h0000_0000;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic       bht_pat  [11] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1};
    logic       bht_pred [11] = '{0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 1};

    initial begin
        // Reset
        #2 rst = 1'b1;
        #1;
        check_eq("rst_pc", pc_F, 32'hBFC0_0000);
        check_eq("rst_addr", inst_addr, 32'hBFC0_0000);
        check_eq("rst_pc_plus", pc_plus_F, 32'hBFC0_0004);
        check_eq("rst_fchange", {31'd0, F_change}, 32'd0);
        step();
        rst = 1'b0;
        step(); step(); step();
        check_eq("seq_pc_c", pc_F, 32'hBFC0_000C);

        // Jump with delay slot
        step();
        check_eq("j_pc", pc_F, 32'hBFC0_0010);
        check_eq("j_instr", instr_F, 32'h0BF0_0040);
        check_eq("j_jump", {31'd0, jump_F}, 32'd1);
        check_eq("j_branch", {31'd0, branch_F}, 32'd0);
        check_eq("j_target", pc_jump_F, 32'hBFC0_0100);
        step();
        check_eq("j_slot_pc", pc_F, 32'hBFC0_0014);
        check_eq("j_slot_fc", {31'd0, F_change}, 32'd1);
        step();
        check_eq("j_tgt_pc", pc_F, 32'hBFC0_0100);
        check_eq("j_tgt_fc", {31'd0, F_change}, 32'd0);

        // Not-taken BEQ (counter 01)
        redirect_E = 1'b1; redirect_pc_E = 32'hBFC0_0020;
        step();
        redirect_E = 1'b0;
        #1;
        check_eq("beq_pc", pc_F, 32'hBFC0_0020);
        check_eq("beq_branch", {31'd0, branch_F}, 32'd1);
        check_eq("beq_pred_nt", {31'd0, pred_take_F}, 32'd0);
        check_eq("beq_target", pc_jump_F, 32'hBFC0_0014);
        step();
        check_eq("beq_nt_slot_pc", pc_F, 32'hBFC0_0024);
        check_eq("beq_nt_slot_fc", {31'd0, F_change}, 32'd1);
        step();
        check_eq("beq_nt_next_pc", pc_F, 32'hBFC0_0028);
        check_eq("beq_nt_next_fc", {31'd0, F_change}, 32'd0);

        // BHT training under stall, observed through pred_take_F at the BEQ
        redirect_E = 1'b1; redirect_pc_E = 32'hBFC0_0020; stall_F = 1'b1;
        step();
        redirect_E = 1'b0;
        for (int i = 0; i < 11; i++) begin
            bht_update_E = 1'b1; bht_pc_E = 32'hBFC0_0020; bht_taken_E = bht_pat[i];
            #1;
            check_eq($sformatf("bht_pred_%0d", i), {31'd0, pred_take_F}, {31'd0, bht_pred[i]});
            step();
        end
        bht_update_E = 1'b0;
        #1;
        check_eq("bht_final_pred", {31'd0, pred_take_F}, 32'd1);
        check_eq("bht_stall_pc", pc_F, 32'hBFC0_0020);

        // Predicted-taken BEQ, stall on the delay slot
        stall_F = 1'b0;
        step();
        check_eq("bt_slot_pc", pc_F, 32'hBFC0_0024);
        check_eq("bt_slot_fc", {31'd0, F_change}, 32'd1);
        stall_F = 1'b1;
        step();
        check_eq("bt_stall1_pc", pc_F, 32'hBFC0_0024);
        step();
        check_eq("bt_stall2_pc", pc_F, 32'hBFC0_0024);
        check_eq("bt_stall2_fc", {31'd0, F_change}, 32'd1);
        stall_F = 1'b0;
        step();
        check_eq("bt_tgt_pc", pc_F, 32'hBFC0_0014);
        check_eq("bt_tgt_fc", {31'd0, F_change}, 32'd0);

        // Redirect while pending and stalled drops the pending target
        redirect_E = 1'b1; redirect_pc_E = 32'hBFC0_0020;
        step();
        redirect_E = 1'b0;
        step();
        check_eq("rd_slot_pc", pc_F, 32'hBFC0_0024);
        stall_F = 1'b1; redirect_E = 1'b1; redirect_pc_E = 32'h8000_1000;
        step();
        redirect_E = 1'b0;
        #1;
        check_eq("rd_pc", pc_F, 32'h8000_1000);
        check_eq("rd_fc", {31'd0, F_change}, 32'd0);
        stall_F = 1'b0;
        step();
        check_eq("rd_no_pend_pc", pc_F, 32'h8000_1004);

        // JR predecode: slot flag but no pending target
        check_eq("jr_is_jr", {31'd0, is_jr_F}, 32'd1);
        check_eq("jr_jump", {31'd0, jump_F}, 32'd0);
        check_eq("jr_target", pc_jump_F, 32'd0);
        step();
        check_eq("jr_slot_pc", pc_F, 32'h8000_1008);
        check_eq("jr_slot_fc", {31'd0, F_change}, 32'd1);
        step();
        check_eq("jr_next_pc", pc_F, 32'h8000_100C);

        // REGIMM BGEZ predecode
        check_eq("bgez_branch", {31'd0, branch_F}, 32'd1);
        check_eq("bgez_target", pc_jump_F, 32'h8000_1020);
        check_eq("bgez_pred", {31'd0, pred_take_F}, 32'd0);

        // Asynchronous reset mid-cycle
        step();
        check_eq("pre_rst_fc", {31'd0, F_change}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_pc", pc_F, 32'hBFC0_0000);
        check_eq("arst_fc", {31'd0, F_change}, 32'd0);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
